// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory bus master: FSM state encoding,
// default bus widths and the address range-check helper.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 6;
  localparam int DMEM_DATA_W = 64;

  // FSM states kept as plain constants so older tools and netlists see a fixed encoding
  typedef logic [2:0] dmem_state_t;

  localparam dmem_state_t ST_IDLE      = 3'd0;
  localparam dmem_state_t ST_RD        = 3'd1;
  localparam dmem_state_t ST_WR_SETUP  = 3'd2;
  localparam dmem_state_t ST_WR_STROBE = 3'd3;
  localparam dmem_state_t ST_WR_HOLD   = 3'd4;

  // A request is addressable only if every bit above the word index is zero
  function automatic logic addr_in_range(input logic [63:0] addr, input int unsigned addr_w);
    return ((addr >> addr_w) == 64'd0);
  endfunction

endpackage

// File: rtl/dmem_store_buffer.sv
// One-entry posted-write buffer for dmem_bus_master. Holds the address and
// data of a store that has already been acknowledged while it drains to memory.
// Only built when DMEM_STORE_BUFFER_EN is defined.
`ifdef DMEM_STORE_BUFFER_EN
module dmem_store_buffer #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              valid,
  output logic [DATA_W-1:0] entry_data,
  output logic              hit
);

  logic [ADDR_W-1:0] entry_addr;

  // Capture a new posted store; drop the entry once its drain has finished
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid      <= 1'b0;
      entry_addr <= '0;
      entry_data <= '0;
    end else if (load) begin
      valid      <= 1'b1;
      entry_addr <= wr_addr;
      entry_data <= wr_data;
    end else if (clear) begin
      valid      <= 1'b0;
    end
  end

  assign hit = valid && (lookup_addr == entry_addr);

endmodule
`endif

// File: rtl/dmem_bus_master.sv
// Initiator for the word-addressed data memory. Accepts MEM-stage load/store
// requests over valid/ready and sequences address, write-enable and the shared
// bidirectional data bus so a write never sees unstable data.
// Optional feature: define DMEM_STORE_BUFFER_EN for a one-entry posted write buffer.
module dmem_bus_master
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = DMEM_ADDR_W,
  parameter int DATA_W    = DMEM_DATA_W,
  parameter int WE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [63:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] d_mem_addr,
  output logic              d_we,
  inout  wire  [DATA_W-1:0] d_mem_data
);

  localparam int               CNT_W    = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WE_CYCLES - 1);

  dmem_state_t       state;
  logic              busy_q;
  logic              drive_en;
  logic [CNT_W-1:0]  we_cnt;
  logic [DATA_W-1:0] bus_wdata;
  logic [ADDR_W-1:0] word_addr;
  logic              in_range;
  logic              accept;

  assign word_addr = req_addr[ADDR_W-1:0];
  assign in_range  = addr_in_range(req_addr, ADDR_W);
  assign accept    = req_valid && req_ready;

  // The bus is only ever driven from a flop-backed enable, never during a read
  assign d_mem_data = drive_en ? bus_wdata : {DATA_W{1'bz}};

`ifdef DMEM_STORE_BUFFER_EN
  logic              sb_valid;
  logic              sb_hit;
  logic              sb_load;
  logic              sb_clear;
  logic [DATA_W-1:0] sb_data;
  logic              hit_pend;
  logic [DATA_W-1:0] hit_data;

  assign sb_load  = accept && (state == ST_IDLE) && req_we && in_range;
  assign sb_clear = (state == ST_WR_HOLD);

  dmem_store_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_store_buffer (
    .clk         (clk),
    .rst         (rst),
    .load        (sb_load),
    .clear       (sb_clear),
    .wr_addr     (word_addr),
    .wr_data     (req_wdata),
    .lookup_addr (word_addr),
    .valid       (sb_valid),
    .entry_data  (sb_data),
    .hit         (sb_hit)
  );

  assign bus_wdata = sb_data;

  // While draining, only loads that hit the buffered word (or fail the range check) can bypass
  assign req_ready = !hit_pend &&
                     ((state == ST_IDLE) || (sb_valid && !req_we && (sb_hit || !in_range)));

  // Stall the pipeline only while a read is on the bus or a request is being held off
  assign busy = (busy_q && !sb_valid) || hit_pend || (req_valid && !req_ready);

  // A load that hits the draining entry is answered from the buffer, no bus read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_pend <= 1'b0;
      hit_data <= '0;
    end else begin
      hit_pend <= accept && sb_valid && in_range;
      if (accept && sb_valid && in_range) begin
        hit_data <= sb_data;
      end
    end
  end
`else
  logic [DATA_W-1:0] wdata_q;

  // Hold the store data from accept so the bus stays stable through setup, strobe and hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdata_q <= '0;
    end else if (accept && req_we && in_range) begin
      wdata_q <= req_wdata;
    end
  end

  assign bus_wdata = wdata_q;
  assign req_ready = (state == ST_IDLE);
  assign busy      = busy_q;
`endif

  // Access sequencer: read is one bus cycle, write is setup / strobe x WE_CYCLES / hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy_q     <= 1'b0;
      drive_en   <= 1'b0;
      d_we       <= 1'b0;
      we_cnt     <= '0;
      d_mem_addr <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
`ifdef DMEM_STORE_BUFFER_EN
      if (hit_pend) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= hit_data;
      end
      if (accept && sb_valid && !in_range) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
`endif
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (!in_range) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (req_we) begin
              d_mem_addr <= word_addr;
              busy_q     <= 1'b1;
              drive_en   <= 1'b1;
              state      <= ST_WR_SETUP;
`ifdef DMEM_STORE_BUFFER_EN
              rsp_valid  <= 1'b1;
`endif
            end else begin
              d_mem_addr <= word_addr;
              busy_q     <= 1'b1;
              state      <= ST_RD;
            end
          end
        end
        ST_RD: begin
          rsp_rdata <= d_mem_data;
          rsp_valid <= 1'b1;
          busy_q    <= 1'b0;
          state     <= ST_IDLE;
        end
        ST_WR_SETUP: begin
          d_we   <= 1'b1;
          we_cnt <= CNT_LAST;
          state  <= ST_WR_STROBE;
        end
        ST_WR_STROBE: begin
          if (we_cnt == '0) begin
            d_we  <= 1'b0;
            state <= ST_WR_HOLD;
          end else begin
            we_cnt <= we_cnt - CNT_W'(1);
          end
        end
        ST_WR_HOLD: begin
          drive_en <= 1'b0;
          busy_q   <= 1'b0;
          state    <= ST_IDLE;
`ifndef DMEM_STORE_BUFFER_EN
          rsp_valid <= 1'b1;
`endif
        end
        default: begin
          state    <= ST_IDLE;
          busy_q   <= 1'b0;
          drive_en <= 1'b0;
          d_we     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_master.sv
// Self-checking bench for dmem_bus_master (default build, blocking stores).
// A behavioural memory sits on the shared bus; a reference model of memory
// contents and per-cycle access timing checks every accepted request.
module tb_dmem_bus_master;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 64;
  localparam int WE     = 2;

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [63:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic [ADDR_W-1:0] d_mem_addr;
  logic              d_we;
  wire  [DATA_W-1:0] d_mem_data;

  logic [63:0] mem     [0:63];
  logic [63:0] ref_mem [0:63];
  logic        tb_oe;
  logic [63:0] last_rdata;
  logic [63:0] got_rdata;
  logic        got_err;
  int          checks;
  int          errors;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        hold;
    logic        exp_err;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  dmem_bus_master #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .WE_CYCLES (WE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .d_mem_addr (d_mem_addr),
    .d_we       (d_we),
    .d_mem_data (d_mem_data)
  );

  // Memory drives its addressed word whenever the master is expected to have released the bus
  assign d_mem_data = tb_oe ? mem[d_mem_addr] : {DATA_W{1'bz}};

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory commits whatever is on the bus while write enable is high
  always @(negedge clk) begin
    if (d_we === 1'b1) mem[d_mem_addr] <= d_mem_data;
  end

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  // Quiet cycles: nothing in flight, bus left to the memory
  task automatic idleCycles(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkBit("idle_busy", busy, 1'b0);
      checkBit("idle_rsp_valid", rsp_valid, 1'b0);
      checkBit("idle_d_we", d_we, 1'b0);
      checkBit("idle_req_ready", req_ready, 1'b1);
      checkOutput("idle_bus_released", d_mem_data, mem[d_mem_addr]);
    end
  endtask

  // Issue one request (called just after a negedge) and check every cycle until its response
  task automatic applyStimulus(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                               input logic keep_valid);
    logic        ok;
    logic        is_store;
    logic        last;
    logic        next_oe;
    logic [63:0] exp_rd;
    int          lat;
    ok       = ((addr >> ADDR_W) == 64'd0);
    is_store = we && ok;
    lat      = !ok ? 1 : (we ? 3 + WE : 2);
    checkBit("ready_at_issue", req_ready, 1'b1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    tb_oe     = !is_store;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      if (!keep_valid) req_valid = 1'b0;
      last = (k == lat - 1);
      checkBit("busy", busy, !last);
      checkBit("rsp_valid", rsp_valid, last);
      checkBit("req_ready", req_ready, last);
      checkBit("d_we", d_we, is_store && (k >= 1) && (k <= WE));
      if (ok) checkOutput("d_mem_addr", 64'(d_mem_addr), 64'(addr[5:0]));
      if (is_store && (k <= WE + 1)) checkOutput("bus_store_data", d_mem_data, wdata);
      else checkOutput("bus_released", d_mem_data, mem[d_mem_addr]);
      if (last) begin
        if (!ok) exp_rd = 64'd0;
        else if (!we) exp_rd = ref_mem[addr[5:0]];
        else exp_rd = last_rdata;
        checkOutput("rsp_rdata", rsp_rdata, exp_rd);
        checkBit("rsp_err", rsp_err, !ok);
        got_rdata = rsp_rdata;
        got_err   = rsp_err;
        if (is_store) ref_mem[addr[5:0]] = wdata;
        last_rdata = exp_rd;
      end else begin
        next_oe = !(is_store && (k + 1 <= WE + 1));
        if (next_oe && !tb_oe) begin
          @(posedge clk);
          #1;
          tb_oe = 1'b1;
        end else begin
          tb_oe = next_oe;
        end
      end
    end
  endtask

  initial begin
    logic        r_we;
    logic [63:0] r_addr;
    logic        r_hold;
    int          r_gap;
    checks     = 0;
    errors     = 0;
    last_rdata = 64'd0;
    got_rdata  = 64'd0;
    got_err    = 1'b0;
    tb_oe      = 1'b1;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 64'h100 + 64'(i);
      ref_mem[i] = 64'h100 + 64'(i);
    end
    mem[1]     = 64'd50;
    ref_mem[1] = 64'd50;

    vecs[0]  = '{1'b0, 64'd1,  64'd0, 1'b0, 1'b0, 64'd50};
    vecs[1]  = '{1'b1, 64'd3,  64'd20, 1'b1, 1'b0, 64'd50};
    vecs[2]  = '{1'b0, 64'd3,  64'd0, 1'b0, 1'b0, 64'd20};
    vecs[3]  = '{1'b0, 64'h40, 64'd0, 1'b0, 1'b1, 64'd0};
    vecs[4]  = '{1'b1, 64'd63, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0, 64'd0};
    vecs[5]  = '{1'b0, 64'd63, 64'd0, 1'b0, 1'b0, 64'hDEAD_BEEF_0123_4567};
    vecs[6]  = '{1'b1, 64'h8000_0000_0000_0005, 64'hAAAA, 1'b0, 1'b1, 64'd0};
    vecs[7]  = '{1'b0, 64'd5,  64'd0, 1'b0, 1'b0, 64'h105};
    vecs[8]  = '{1'b0, 64'd0,  64'd0, 1'b0, 1'b0, 64'h100};
    vecs[9]  = '{1'b1, 64'd0,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'h100};
    vecs[10] = '{1'b0, 64'd0,  64'd0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 64'd0;
    req_wdata = 64'd0;
    #3;
    checkBit("reset_req_ready", req_ready, 1'b1);
    checkBit("reset_rsp_valid", rsp_valid, 1'b0);
    checkBit("reset_rsp_err", rsp_err, 1'b0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 64'd0);
    checkBit("reset_busy", busy, 1'b0);
    checkOutput("reset_d_mem_addr", 64'(d_mem_addr), 64'd0);
    checkBit("reset_d_we", d_we, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idleCycles(2);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].hold);
      checkOutput($sformatf("vec%0d_rdata", i), got_rdata, vecs[i].exp_rdata);
      checkBit($sformatf("vec%0d_err", i), got_err, vecs[i].exp_err);
    end
    idleCycles(2);

    req_we    = 1'b1;
    req_addr  = 64'd9;
    req_wdata = 64'h5555_0000_5555_0000;
    req_valid = 1'b1;
    tb_oe     = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkBit("midrst_d_we", d_we, 1'b0);
    checkBit("midrst_busy", busy, 1'b0);
    checkBit("midrst_rsp_valid", rsp_valid, 1'b0);
    checkBit("midrst_req_ready", req_ready, 1'b1);
    checkOutput("midrst_d_mem_addr", 64'(d_mem_addr), 64'd0);
    checkOutput("midrst_rsp_rdata", rsp_rdata, 64'd0);
    req_valid = 1'b0;
    tb_oe     = 1'b1;
    last_rdata = 64'd0;
    @(negedge clk);
    rst = 1'b0;
    idleCycles(3);
    checkOutput("midrst_mem_word9", mem[9], ref_mem[9]);
    applyStimulus(1'b0, 64'd9, 64'd0, 1'b0);
    checkOutput("midrst_load9", got_rdata, 64'h109);
    idleCycles(1);

    for (int t = 0; t < 40; t++) begin
      r_we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) r_addr = {$urandom, $urandom} | 64'h40;
      else r_addr = 64'($urandom_range(0, 63));
      r_gap  = $urandom_range(0, 2);
      r_hold = (r_gap == 0) && (t != 39) && ($urandom_range(0, 1) == 1);
      applyStimulus(r_we, r_addr, {$urandom, $urandom}, r_hold);
      if (r_gap > 0) idleCycles(r_gap);
    end
    idleCycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
